// File: rtl/graphics_port_arbiter.sv
// graphics_port_arbiter
//   Shares graphics BRAM port A between the CPU data bus and the blitter/fill
//   engine. The CPU wins by default. A blitter that keeps waiting gets one beat
//   once it has waited STARVE_LIMIT cycles. The blitter may hold the port with
//   blt_lock for up to LOCK_MAX consecutive beats. Read data comes back two
//   cycles after the accept and goes to the requester that issued the read.
//
// Ports
//   bus_clk_2x, rst                    clock, asynchronous active-high reset
//   cpu_req/we/mask/addr/wdata         CPU request fields
//   cpu_gnt                            CPU beat accepted this cycle (combinational)
//   cpu_rvalid, cpu_rdata              CPU read return
//   blt_req/we/mask/addr/wdata/lock    blitter request fields, lock keeps the grant
//   blt_gnt, blt_rvalid, blt_rdata     blitter accept / read return
//   mem_addr, mem_we, mem_wdata        registered BRAM port-A command
//   mem_rdata                          BRAM port-A read data (1-cycle latency)
//   locked                             arbiter is holding the port for the blitter
`timescale 1ns/1ps
module graphics_port_arbiter #(
  parameter int ADDR_WIDTH   = 17,
  parameter int STARVE_LIMIT = 4,
  parameter int LOCK_MAX     = 8
) (
  input  logic                  bus_clk_2x,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [3:0]            cpu_mask,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [31:0]           cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [31:0]           cpu_rdata,
  input  logic                  blt_req,
  input  logic                  blt_we,
  input  logic [3:0]            blt_mask,
  input  logic [ADDR_WIDTH-1:0] blt_addr,
  input  logic [31:0]           blt_wdata,
  input  logic                  blt_lock,
  output logic                  blt_gnt,
  output logic                  blt_rvalid,
  output logic [31:0]           blt_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_we,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic                  locked
);

  typedef enum logic [0:0] {S_NORMAL = 1'b0, S_LOCKED = 1'b1} state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] LOCK_LIM   = 8'(LOCK_MAX);
  localparam logic       LOCK_EN    = (LOCK_MAX > 1) ? 1'b1 : 1'b0;

  state_t                  state_q, state_d;
  logic [3:0]              starve_cnt_q, starve_cnt_d;
  logic [7:0]              lock_cnt_q, lock_cnt_d;
  logic                    cpu_gnt_s, blt_gnt_s, accept_s;
  logic                    win_we_s;
  logic [3:0]              win_mask_s;
  logic [ADDR_WIDTH-1:0]   win_addr_s;
  logic [31:0]             win_wdata_s;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [3:0]              mem_we_q;
  logic [31:0]             mem_wdata_q;
  logic                    tag1_valid_q, tag1_blt_q;
  logic                    cpu_rvalid_q, blt_rvalid_q;

  // Grant decision from current requests and arbiter state
  always_comb begin
    cpu_gnt_s = 1'b0;
    blt_gnt_s = 1'b0;
    case (state_q)
      S_NORMAL: begin
        if (blt_req && (!cpu_req || (starve_cnt_q == STARVE_MAX))) begin
          blt_gnt_s = 1'b1;
        end else if (cpu_req) begin
          cpu_gnt_s = 1'b1;
        end else begin
          cpu_gnt_s = 1'b0;
        end
      end
      S_LOCKED: begin
        blt_gnt_s = blt_req;
      end
      default: begin
        cpu_gnt_s = 1'b0;
        blt_gnt_s = 1'b0;
      end
    endcase
  end

  assign accept_s = cpu_gnt_s | blt_gnt_s;

  // Select the winning requester's command fields
  always_comb begin
    win_we_s    = cpu_we;
    win_mask_s  = cpu_mask;
    win_addr_s  = cpu_addr;
    win_wdata_s = cpu_wdata;
    if (blt_gnt_s) begin
      win_we_s    = blt_we;
      win_mask_s  = blt_mask;
      win_addr_s  = blt_addr;
      win_wdata_s = blt_wdata;
    end else begin
      win_we_s    = cpu_we;
      win_mask_s  = cpu_mask;
      win_addr_s  = cpu_addr;
      win_wdata_s = cpu_wdata;
    end
  end

  // Next state, starvation counter and lock beat counter
  // Leaving S_LOCKED always leaves starve_cnt at 0, so a waiting CPU wins the
  // following cycle whatever the blitter does (covers the LOCK_MAX cut).
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    lock_cnt_d   = lock_cnt_q;
    case (state_q)
      S_NORMAL: begin
        if (blt_gnt_s || !blt_req) begin
          starve_cnt_d = 4'd0;
        end else if (starve_cnt_q != STARVE_MAX) begin
          starve_cnt_d = starve_cnt_q + 4'd1;
        end else begin
          starve_cnt_d = starve_cnt_q;
        end
        if (blt_gnt_s && blt_lock && LOCK_EN) begin
          state_d    = S_LOCKED;
          lock_cnt_d = 8'd1;
        end else begin
          lock_cnt_d = 8'd0;
        end
      end
      S_LOCKED: begin
        starve_cnt_d = 4'd0;
        if (!blt_req || !blt_lock || ((lock_cnt_q + 8'd1) == LOCK_LIM)) begin
          state_d    = S_NORMAL;
          lock_cnt_d = 8'd0;
        end else begin
          lock_cnt_d = lock_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d      = S_NORMAL;
        starve_cnt_d = 4'd0;
        lock_cnt_d   = 8'd0;
      end
    endcase
  end

  // Arbiter state registers
  always_ff @(posedge bus_clk_2x or posedge rst) begin
    if (rst) begin
      state_q      <= S_NORMAL;
      starve_cnt_q <= 4'd0;
      lock_cnt_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      lock_cnt_q   <= lock_cnt_d;
    end
  end

  // BRAM command register; address and data hold when nothing is accepted
  always_ff @(posedge bus_clk_2x or posedge rst) begin
    if (rst) begin
      mem_addr_q  <= '0;
      mem_we_q    <= 4'b0000;
      mem_wdata_q <= 32'h0000_0000;
    end else if (accept_s) begin
      mem_addr_q  <= win_addr_s;
      mem_we_q    <= win_we_s ? win_mask_s : 4'b0000;
      mem_wdata_q <= win_wdata_s;
    end else begin
      mem_we_q    <= 4'b0000;
    end
  end

  // Two-stage read tag pipeline: stage 1 tracks the BRAM address cycle,
  // stage 2 is the cycle the BRAM data is valid
  always_ff @(posedge bus_clk_2x or posedge rst) begin
    if (rst) begin
      tag1_valid_q <= 1'b0;
      tag1_blt_q   <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      blt_rvalid_q <= 1'b0;
    end else begin
      tag1_valid_q <= accept_s && !win_we_s;
      tag1_blt_q   <= blt_gnt_s;
      cpu_rvalid_q <= tag1_valid_q && !tag1_blt_q;
      blt_rvalid_q <= tag1_valid_q && tag1_blt_q;
    end
  end

  assign cpu_gnt    = cpu_gnt_s;
  assign blt_gnt    = blt_gnt_s;
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign blt_rvalid = blt_rvalid_q;
  assign cpu_rdata  = cpu_rvalid_q ? mem_rdata : 32'h0000_0000;
  assign blt_rdata  = blt_rvalid_q ? mem_rdata : 32'h0000_0000;
  assign locked     = (state_q == S_LOCKED) ? 1'b1 : 1'b0;

endmodule

// File: tb/tb_graphics_port_arbiter.sv
// Testbench for graphics_port_arbiter: a BRAM port-A model, a transaction-level
// reference model, a vector table, directed corner-case sequences and random traffic.
`timescale 1ns/1ps
module tb_graphics_port_arbiter;

  localparam int AW     = 17;
  localparam int STARVE = 4;
  localparam int LOCKM  = 8;

  logic          bus_clk_2x = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [3:0]    cpu_mask;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_wdata, cpu_rdata;
  logic          blt_req, blt_we, blt_lock, blt_gnt, blt_rvalid;
  logic [3:0]    blt_mask;
  logic [AW-1:0] blt_addr;
  logic [31:0]   blt_wdata, blt_rdata;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_we;
  logic [31:0]   mem_wdata, mem_rdata;
  logic          locked;

  graphics_port_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(STARVE), .LOCK_MAX(LOCKM)) dut (
    .bus_clk_2x(bus_clk_2x), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_mask(cpu_mask), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .blt_req(blt_req), .blt_we(blt_we), .blt_mask(blt_mask), .blt_addr(blt_addr),
    .blt_wdata(blt_wdata), .blt_lock(blt_lock), .blt_gnt(blt_gnt), .blt_rvalid(blt_rvalid),
    .blt_rdata(blt_rdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .locked(locked)
  );

  always #5 bus_clk_2x = ~bus_clk_2x;

  // BRAM port-A model: read-first, one cycle latency, byte write enables, backdoor load
  bit [31:0]     bram [0:131071];
  logic          bd_en = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [31:0]   bd_data = 32'h0;
  always @(posedge bus_clk_2x) begin
    mem_rdata <= bram[mem_addr];
    if (mem_we[0]) bram[mem_addr][7:0]   <= mem_wdata[7:0];
    if (mem_we[1]) bram[mem_addr][15:8]  <= mem_wdata[15:8];
    if (mem_we[2]) bram[mem_addr][23:16] <= mem_wdata[23:16];
    if (mem_we[3]) bram[mem_addr][31:24] <= mem_wdata[31:24];
    if (bd_en) bram[bd_addr] <= bd_data;
  end

  typedef struct {
    logic          cpu_req, cpu_we, blt_req, blt_we, blt_lock;
    logic [3:0]    cpu_mask, blt_mask;
    logic [AW-1:0] cpu_addr, blt_addr;
    logic [31:0]   cpu_wdata, blt_wdata;
    int            exp_c, exp_b, exp_l;   // -1 = no explicit expectation
  } vec_t;

  typedef struct {
    int          due;
    bit          blt;
    logic [31:0] data;
  } ret_t;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [31:0]   ref_mem [int];
  ret_t          pend [$];
  int            cyc;
  int            m_wait, m_beats;
  bit            m_locked;
  logic [AW-1:0] e_addr;
  logic [3:0]    e_we;
  logic [31:0]   e_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_rd(input int a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return 32'h0;
  endfunction

  task automatic ref_wr(input int a, input logic [3:0] m, input logic [31:0] d);
    logic [31:0] w;
    w = ref_rd(a);
    for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
    ref_mem[a] = w;
  endtask

  task automatic model_reset();
    pend.delete();
    m_wait = 0; m_beats = 0; m_locked = 1'b0;
    e_addr = '0; e_we = 4'b0000; e_wdata = 32'h0;
  endtask

  function automatic vec_t mk(input bit cr, input bit cw, input logic [AW-1:0] ca,
                              input bit br, input bit bw, input logic [AW-1:0] ba,
                              input bit bl, input int ec, input int eb, input int el);
    vec_t v;
    v.cpu_req = cr; v.cpu_we = cw; v.cpu_mask = 4'hF; v.cpu_addr = ca;
    v.cpu_wdata = 32'hC000_0000 | {15'h0, ca};
    v.blt_req = br; v.blt_we = bw; v.blt_mask = 4'b1100; v.blt_addr = ba;
    v.blt_wdata = 32'hB000_0000 | {15'h0, ba};
    v.blt_lock = bl; v.exp_c = ec; v.exp_b = eb; v.exp_l = el;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    cpu_req = v.cpu_req; cpu_we = v.cpu_we; cpu_mask = v.cpu_mask;
    cpu_addr = v.cpu_addr; cpu_wdata = v.cpu_wdata;
    blt_req = v.blt_req; blt_we = v.blt_we; blt_mask = v.blt_mask;
    blt_addr = v.blt_addr; blt_wdata = v.blt_wdata; blt_lock = v.blt_lock;
  endtask

  // One bus cycle: drive after the edge, sample at the falling edge, compare
  // with the reference model (and any explicit expectations), advance the model.
  task automatic cycle(input vec_t v);
    int          win;
    logic [31:0] x_cd, x_bd;
    bit          x_cv, x_bv;
    @(posedge bus_clk_2x); #1;
    drive(v);
    @(negedge bus_clk_2x);
    if (m_locked) win = v.blt_req ? 2 : 0;
    else if (v.blt_req && (!v.cpu_req || m_wait >= STARVE)) win = 2;
    else if (v.cpu_req) win = 1;
    else win = 0;
    x_cv = 1'b0; x_bv = 1'b0; x_cd = 32'h0; x_bd = 32'h0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      if (pend[0].blt) begin x_bv = 1'b1; x_bd = pend[0].data; end
      else begin x_cv = 1'b1; x_cd = pend[0].data; end
      void'(pend.pop_front());
    end
    chk("cpu_gnt", 32'(cpu_gnt), 32'(win == 1));
    chk("blt_gnt", 32'(blt_gnt), 32'(win == 2));
    chk("locked", 32'(locked), 32'(m_locked));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(x_cv));
    chk("blt_rvalid", 32'(blt_rvalid), 32'(x_bv));
    chk("cpu_rdata", cpu_rdata, x_cd);
    chk("blt_rdata", blt_rdata, x_bd);
    if (v.exp_c >= 0) chk("exp_cpu_gnt", 32'(cpu_gnt), 32'(v.exp_c != 0));
    if (v.exp_b >= 0) chk("exp_blt_gnt", 32'(blt_gnt), 32'(v.exp_b != 0));
    if (v.exp_l >= 0) chk("exp_locked", 32'(locked), 32'(v.exp_l != 0));
    // advance model
    if (m_locked) begin
      m_wait = 0;
      if (!v.blt_req || !v.blt_lock || m_beats + 1 >= LOCKM) begin
        m_locked = 1'b0; m_beats = 0;
      end else begin
        m_beats++;
      end
    end else if (win == 2) begin
      m_wait = 0;
      if (v.blt_lock && LOCKM > 1) begin m_locked = 1'b1; m_beats = 1; end
    end else if (v.blt_req) begin
      if (m_wait < STARVE) m_wait++;
    end else begin
      m_wait = 0;
    end
    if (win != 0) begin
      ret_t r;
      logic          w_we;
      logic [3:0]    w_m;
      logic [AW-1:0] w_a;
      logic [31:0]   w_d;
      w_we = (win == 2) ? v.blt_we : v.cpu_we;
      w_m  = (win == 2) ? v.blt_mask : v.cpu_mask;
      w_a  = (win == 2) ? v.blt_addr : v.cpu_addr;
      w_d  = (win == 2) ? v.blt_wdata : v.cpu_wdata;
      e_addr = w_a; e_wdata = w_d; e_we = w_we ? w_m : 4'b0000;
      if (w_we) begin
        ref_wr(int'(w_a), w_m, w_d);
      end else begin
        r.due = cyc + 2; r.blt = (win == 2); r.data = ref_rd(int'(w_a));
        pend.push_back(r);
      end
    end else begin
      e_we = 4'b0000;
    end
    cyc++;
  endtask

  task automatic preload(input int a, input logic [31:0] d);
    bd_en = 1'b1; bd_addr = AW'(a); bd_data = d; ref_mem[a] = d;
    @(posedge bus_clk_2x); #1;
    bd_en = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_rvalid"}, 32'({cpu_rvalid, blt_rvalid}), 32'h0);
    chk({tag, "_cpu_rdata"}, cpu_rdata, 32'h0);
    chk({tag, "_blt_rdata"}, blt_rdata, 32'h0);
    chk({tag, "_gnt"}, 32'({cpu_gnt, blt_gnt}), 32'h0);
    chk({tag, "_locked"}, 32'(locked), 32'h0);
  endtask

  vec_t tbl [15];
  vec_t idle, v;

  initial begin
    idle = mk(0, 0, '0, 0, 0, '0, 0, -1, -1, -1);
    tbl[0]  = mk(0, 0, 17'h00, 0, 0, 17'h00, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 17'h20, 0, 0, 17'h00, 0, 1, 0, 0);
    tbl[2]  = mk(0, 0, 17'h00, 1, 1, 17'h21, 0, 0, 1, 0);
    tbl[3]  = mk(1, 0, 17'h22, 1, 0, 17'h23, 0, 1, 0, 0);
    tbl[4]  = mk(1, 0, 17'h22, 1, 0, 17'h23, 0, 1, 0, 0);
    tbl[5]  = mk(1, 1, 17'h24, 0, 0, 17'h00, 0, 1, 0, 0);
    tbl[6]  = mk(1, 0, 17'h21, 1, 0, 17'h23, 0, 1, 0, 0);
    tbl[7]  = mk(1, 0, 17'h22, 1, 0, 17'h23, 0, 1, 0, 0);
    tbl[8]  = mk(1, 0, 17'h22, 1, 0, 17'h23, 0, 1, 0, 0);
    tbl[9]  = mk(1, 0, 17'h22, 1, 0, 17'h23, 0, 1, 0, 0);
    tbl[10] = mk(1, 0, 17'h22, 1, 0, 17'h24, 1, 0, 1, 0);
    tbl[11] = mk(1, 0, 17'h22, 1, 1, 17'h25, 1, 0, 1, 1);
    tbl[12] = mk(1, 0, 17'h22, 0, 0, 17'h00, 1, 0, 0, 1);
    tbl[13] = mk(1, 0, 17'h25, 1, 0, 17'h26, 0, 1, 0, 0);
    tbl[14] = mk(0, 0, 17'h00, 0, 0, 17'h00, 0, 0, 0, 0);

    cyc = 0;
    model_reset();
    rst = 1'b1;
    drive(idle);
    repeat (2) @(posedge bus_clk_2x);
    #1;
    preload(32'h10, 32'hDEAD_BEEF);
    preload(1, 32'h0000_000A);
    preload(2, 32'h0000_000B);
    preload(3, 32'h0000_000C);
    @(negedge bus_clk_2x);
    chk_reset_vals("reset");
    @(posedge bus_clk_2x); #1;
    rst = 1'b0;

    // vector table
    for (int i = 0; i < 15; i++) cycle(tbl[i]);

    // CPU-only read of 0x10
    cycle(mk(1, 0, 17'h10, 0, 0, '0, 0, 1, 0, 0));
    cycle(idle);
    chk("rd_mem_addr", 32'(mem_addr), 32'h10);
    chk("rd_mem_we", 32'(mem_we), 32'h0);
    cycle(idle);
    chk("rd_cpu_rvalid", 32'(cpu_rvalid), 32'h1);
    chk("rd_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("rd_blt_rvalid", 32'(blt_rvalid), 32'h0);
    cycle(idle);
    chk("rd_cpu_rvalid_once", 32'(cpu_rvalid), 32'h0);

    // CPU partial write
    v = mk(1, 1, 17'h1D4BF, 0, 0, '0, 0, 1, 0, 0);
    v.cpu_mask = 4'b0011; v.cpu_wdata = 32'h1234_5678;
    cycle(v);
    cycle(idle);
    chk("wr_mem_we", 32'(mem_we), 32'h3);
    chk("wr_mem_wdata", mem_wdata, 32'h1234_5678);
    chk("wr_mem_addr", 32'(mem_addr), 32'h1D4BF);
    cycle(idle);
    chk("wr_mem_we_idle", 32'(mem_we), 32'h0);
    chk("wr_no_rvalid", 32'({cpu_rvalid, blt_rvalid}), 32'h0);

    // Starvation: both request for 20 cycles, expect C,C,C,C,B repeating
    cycle(idle);
    for (int i = 0; i < 20; i++) begin
      cycle(mk(1, 0, 17'h30, 1, 0, 17'h31, 0, (i % 5 == 4) ? 0 : 1, (i % 5 == 4) ? 1 : 0, 0));
      chk("onehot_gnt", 32'(cpu_gnt & blt_gnt), 32'h0);
    end
    repeat (3) cycle(idle);

    // Interleaved reads C(1) / B(2) / C(3)
    cycle(mk(1, 0, 17'h1, 0, 0, '0, 0, 1, 0, 0));
    cycle(mk(0, 0, '0, 1, 0, 17'h2, 0, 0, 1, 0));
    cycle(mk(1, 0, 17'h3, 0, 0, '0, 0, 1, 0, 0));
    chk("il_cpu_rvalid_a", 32'(cpu_rvalid), 32'h1);
    chk("il_cpu_rdata_a", cpu_rdata, 32'hA);
    cycle(idle);
    chk("il_blt_rvalid_b", 32'(blt_rvalid), 32'h1);
    chk("il_blt_rdata_b", blt_rdata, 32'hB);
    cycle(idle);
    chk("il_cpu_rvalid_c", 32'(cpu_rvalid), 32'h1);
    chk("il_cpu_rdata_c", cpu_rdata, 32'hC);
    cycle(idle);

    // Lock released by blt_lock=0 on the 4th beat, CPU requesting throughout
    cycle(idle);
    for (int k = 0; k < 9; k++)
      cycle(mk(1, 0, 17'h50, 1, 1, AW'(17'h40 + k), (k < 7) ? 1'b1 : 1'b0,
               (k < 4 || k == 8) ? 1 : 0, (k >= 4 && k < 8) ? 1 : 0,
               (k >= 5 && k < 8) ? 1 : 0));
    repeat (2) cycle(idle);

    // Lock held for 10 beats is cut at LOCK_MAX, then the CPU gets a beat
    for (int k = 0; k < 13; k++)
      cycle(mk(1, 0, 17'h51, 1, 1, AW'(17'h60 + k), 1,
               (k < 4 || k == 12) ? 1 : 0, (k >= 4 && k < 12) ? 1 : 0,
               (k >= 5 && k < 12) ? 1 : 0));
    repeat (3) cycle(idle);

    // Reset pulsed one cycle after a CPU read accept
    cycle(mk(1, 0, 17'h10, 0, 0, '0, 0, 1, 0, 0));
    @(posedge bus_clk_2x); #1;
    rst = 1'b1;
    drive(idle);
    @(negedge bus_clk_2x);
    chk_reset_vals("mid_rst");
    @(posedge bus_clk_2x); #1;
    rst = 1'b0;
    model_reset();
    @(negedge bus_clk_2x);
    chk("mid_rst_no_rvalid", 32'(cpu_rvalid), 32'h0);
    chk("mid_rst_no_rdata", cpu_rdata, 32'h0);
    repeat (3) cycle(idle);
    chk("mid_rst_locked", 32'(locked), 32'h0);

    // Random traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      v = idle;
      v.cpu_req   = ($urandom_range(0, 3) != 0);
      v.cpu_we    = $urandom_range(0, 1) != 0;
      v.cpu_mask  = 4'($urandom_range(0, 15));
      v.cpu_addr  = 17'h100 + 17'($urandom_range(0, 15));
      v.cpu_wdata = $urandom;
      v.blt_req   = $urandom_range(0, 1) != 0;
      v.blt_we    = $urandom_range(0, 1) != 0;
      v.blt_mask  = 4'($urandom_range(0, 15));
      v.blt_addr  = 17'h100 + 17'($urandom_range(0, 15));
      v.blt_wdata = $urandom;
      v.blt_lock  = ($urandom_range(0, 2) != 0);
      cycle(v);
      chk("rand_onehot_gnt", 32'(cpu_gnt & blt_gnt), 32'h0);
    end
    repeat (3) cycle(idle);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
